// File: rtl/ast_pkt_pkg.sv
// Shared types and helpers for the packet-aware Avalon-ST FIFO.
package ast_pkt_pkg;

   localparam int unsigned RL_MAX              = 4;
   localparam int unsigned DATABITS_PER_SYMBOL = 8;
   localparam int unsigned SYMBOLS_PER_BEAT    = 4;
   localparam int unsigned WIDTH               = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

   // Width of the empty-symbol count; never narrower than one bit.
   function automatic int unsigned empty_w(input int unsigned symbols);
      return (symbols > 1) ? $clog2(symbols) : 1;
   endfunction

   // Address width for a power-of-2 depth.
   function automatic int unsigned addr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   localparam int unsigned EMPTY_W = empty_w(SYMBOLS_PER_BEAT);

   typedef struct packed {
      logic [WIDTH-1:0]   data;
      logic               sop;
      logic               eop;
      logic [EMPTY_W-1:0] empty;
   } ast_beat_t;

   localparam int unsigned BEAT_W = $bits(ast_beat_t);

   // Store-and-forward gate: hold until a full packet is stored, or cut through an oversized one.
   typedef enum logic {
      SF_STORE = 1'b0,
      SF_CUT   = 1'b1
   } sf_state_t;

endpackage

// File: rtl/ast_pkt_fifo_ram.sv
// Beat storage: synchronous write, asynchronous (show-ahead) read.
module ast_pkt_fifo_ram
   import ast_pkt_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [BEAT_W-1:0] i_wbeat,
   input  logic [AW-1:0]     i_raddr,
   output logic [BEAT_W-1:0] o_rbeat
);

   logic [BEAT_W-1:0] r_mem [DEPTH];

   // Write port; contents are don't-care until written, so no reset.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wbeat;
      end
   end

   assign o_rbeat = r_mem[i_raddr];

endmodule

// File: rtl/ast_pkt_fifo.sv
// Packet-aware Avalon-ST FIFO with ready-latency credit tracking and optional store-and-forward.
// Beat geometry (data width, empty width) comes from ast_pkt_pkg.
module ast_pkt_fifo
   import ast_pkt_pkg::*;
#(
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned READY_LATENCY = 0,
   parameter int unsigned STORE_AND_FWD = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [WIDTH-1:0]        snk_data_i,
   input  logic                    snk_valid_i,
   input  logic                    snk_sop_i,
   input  logic                    snk_eop_i,
   input  logic [EMPTY_W-1:0]      snk_empty_i,
   output logic                    snk_ready_o,
   output logic [WIDTH-1:0]        src_data_o,
   output logic                    src_valid_o,
   output logic                    src_sop_o,
   output logic                    src_eop_o,
   output logic [EMPTY_W-1:0]      src_empty_o,
   input  logic                    src_ready_i,
   output logic [addr_w(DEPTH):0]  usedw_o,
   output logic [addr_w(DEPTH):0]  pkt_cnt_o,
   output logic                    ovf_o
);

   localparam int unsigned AW = addr_w(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = AW + 2;

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_usedw;
   logic [CW-1:0] r_pkt_cnt;
   logic          r_ovf;
   sf_state_t     r_sf_state;
   sf_state_t     w_sf_state_nxt;

   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_drop;
   logic          w_src_valid;
   logic          w_snk_ready;
   logic [CW-1:0] w_inflight;
   logic [SW-1:0] w_credit_used;
   ast_beat_t     w_wbeat;
   ast_beat_t     w_rbeat;

   // Ready history: beats promised by earlier ready cycles that have not landed yet.
   generate
      if (READY_LATENCY == 0) begin : g_rl0
         assign w_inflight = '0;
      end else begin : g_rl
         logic [READY_LATENCY-1:0] r_ready_hist;

         // Shift the current ready into the history every cycle.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               r_ready_hist <= '0;
            end else begin
               r_ready_hist <= (r_ready_hist << 1) | READY_LATENCY'(w_snk_ready);
            end
         end

         // Count outstanding ready grants.
         always_comb begin
            w_inflight = '0;
            for (int i = 0; i < int'(READY_LATENCY); i++) begin
               w_inflight = w_inflight + CW'(r_ready_hist[i]);
            end
         end
      end
   endgenerate

   assign w_credit_used = SW'(r_usedw) + SW'(w_inflight);
   assign w_snk_ready   = w_credit_used < SW'(DEPTH);

   assign w_full      = (r_usedw == CW'(DEPTH));
   assign w_src_valid = (r_usedw != '0) &&
                        ((STORE_AND_FWD == 0) || (r_pkt_cnt != '0) || (r_sf_state == SF_CUT));
   assign w_pop       = w_src_valid && src_ready_i;
   // A pop on the same edge frees the slot, so a full FIFO still accepts push+pop.
   assign w_push      = snk_valid_i && (!w_full || w_pop);
   assign w_drop      = snk_valid_i && w_full && !w_pop;

   // Pack the incoming beat with its sideband.
   always_comb begin
      w_wbeat.data  = snk_data_i;
      w_wbeat.sop   = snk_sop_i;
      w_wbeat.eop   = snk_eop_i;
      w_wbeat.empty = snk_empty_i;
   end

   ast_pkt_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .i_clk   (clk_i),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wbeat (w_wbeat),
      .i_raddr (r_rd_ptr),
      .o_rbeat (w_rbeat)
   );

   // Pointers, occupancy, packet count and sticky overflow.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_usedw   <= '0;
         r_pkt_cnt <= '0;
         r_ovf     <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_usedw <= r_usedw + CW'(1);
            2'b01:   r_usedw <= r_usedw - CW'(1);
            default: r_usedw <= r_usedw;
         endcase
         case ({w_push && snk_eop_i, w_pop && w_rbeat.eop})
            2'b10:   r_pkt_cnt <= r_pkt_cnt + CW'(1);
            2'b01:   r_pkt_cnt <= r_pkt_cnt - CW'(1);
            default: r_pkt_cnt <= r_pkt_cnt;
         endcase
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
      end
   end

   // Store-and-forward state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sf_state <= SF_STORE;
      end else begin
         r_sf_state <= w_sf_state_nxt;
      end
   end

   // Cut through when the FIFO fills without a complete packet; resume storing after its eop leaves.
   always_comb begin
      w_sf_state_nxt = r_sf_state;
      case (r_sf_state)
         SF_STORE: if (w_full && (r_pkt_cnt == '0)) w_sf_state_nxt = SF_CUT;
         SF_CUT:   if (w_pop && w_rbeat.eop)        w_sf_state_nxt = SF_STORE;
         default:  w_sf_state_nxt = SF_STORE;
      endcase
   end

   assign snk_ready_o = w_snk_ready;
   assign src_valid_o = w_src_valid;
   assign src_data_o  = w_src_valid ? w_rbeat.data  : '0;
   assign src_sop_o   = w_src_valid & w_rbeat.sop;
   assign src_eop_o   = w_src_valid & w_rbeat.eop;
   assign src_empty_o = w_src_valid ? w_rbeat.empty : '0;
   assign usedw_o     = r_usedw;
   assign pkt_cnt_o   = r_pkt_cnt;
   assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_ast_pkt_fifo.sv
// Bench for ast_pkt_fifo: three configurations driven from shared inputs, checked against a queue model.
module tb_ast_pkt_fifo;
   import ast_pkt_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned UW    = 5;

   logic                clk;
   logic                rst;
   logic [WIDTH-1:0]    snk_data;
   logic                snk_valid;
   logic                snk_sop;
   logic                snk_eop;
   logic [EMPTY_W-1:0]  snk_empty;
   logic                src_ready;

   logic                x_ready [3];
   logic [WIDTH-1:0]    x_data  [3];
   logic                x_valid [3];
   logic                x_sop   [3];
   logic                x_eop   [3];
   logic [EMPTY_W-1:0]  x_empty [3];
   logic [UW-1:0]       x_usedw [3];
   logic [UW-1:0]       x_pkt   [3];
   logic                x_ovf   [3];

   // Model state
   ast_beat_t q[$];
   bit        rh[$];
   int        sel;
   int        m_rl;
   bit        m_sf, m_cut, m_ovf, m_valid, m_ready, m_pop_v;
   int        m_usedw, m_pkt;
   ast_beat_t m_pop_beat;
   ast_beat_t d_beat;
   bit        d_pop, d_ready;

   int n_total = 0;
   int n_bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ast_pkt_fifo #(.DEPTH(DEPTH), .READY_LATENCY(0), .STORE_AND_FWD(0)) dut_rl0 (
      .clk_i(clk), .rst_i(rst), .snk_data_i(snk_data), .snk_valid_i(snk_valid),
      .snk_sop_i(snk_sop), .snk_eop_i(snk_eop), .snk_empty_i(snk_empty), .snk_ready_o(x_ready[0]),
      .src_data_o(x_data[0]), .src_valid_o(x_valid[0]), .src_sop_o(x_sop[0]), .src_eop_o(x_eop[0]),
      .src_empty_o(x_empty[0]), .src_ready_i(src_ready), .usedw_o(x_usedw[0]), .pkt_cnt_o(x_pkt[0]),
      .ovf_o(x_ovf[0]));

   ast_pkt_fifo #(.DEPTH(DEPTH), .READY_LATENCY(2), .STORE_AND_FWD(0)) dut_rl2 (
      .clk_i(clk), .rst_i(rst), .snk_data_i(snk_data), .snk_valid_i(snk_valid),
      .snk_sop_i(snk_sop), .snk_eop_i(snk_eop), .snk_empty_i(snk_empty), .snk_ready_o(x_ready[1]),
      .src_data_o(x_data[1]), .src_valid_o(x_valid[1]), .src_sop_o(x_sop[1]), .src_eop_o(x_eop[1]),
      .src_empty_o(x_empty[1]), .src_ready_i(src_ready), .usedw_o(x_usedw[1]), .pkt_cnt_o(x_pkt[1]),
      .ovf_o(x_ovf[1]));

   ast_pkt_fifo #(.DEPTH(DEPTH), .READY_LATENCY(0), .STORE_AND_FWD(1)) dut_sf (
      .clk_i(clk), .rst_i(rst), .snk_data_i(snk_data), .snk_valid_i(snk_valid),
      .snk_sop_i(snk_sop), .snk_eop_i(snk_eop), .snk_empty_i(snk_empty), .snk_ready_o(x_ready[2]),
      .src_data_o(x_data[2]), .src_valid_o(x_valid[2]), .src_sop_o(x_sop[2]), .src_eop_o(x_eop[2]),
      .src_empty_o(x_empty[2]), .src_ready_i(src_ready), .usedw_o(x_usedw[2]), .pkt_cnt_o(x_pkt[2]),
      .ovf_o(x_ovf[2]));

   // Derive the model's visible outputs from its stored beats.
   task automatic model_eval();
      int pc;
      int infl;
      pc = 0;
      foreach (q[i]) if (q[i].eop) pc++;
      infl = 0;
      foreach (rh[i]) if (rh[i]) infl++;
      m_usedw = q.size();
      m_pkt   = pc;
      m_valid = (q.size() != 0) && (!m_sf || (pc != 0) || m_cut);
      m_ready = (int'(DEPTH) - q.size() - infl) > 0;
   endtask

   // Advance one clock: record what leaves (model and DUT), apply push/pop to the model.
   task automatic step();
      bit        mp;
      bit        full;
      bit        nc;
      ast_beat_t nb;
      d_pop        = x_valid[sel] && src_ready;
      d_beat.data  = x_data[sel];
      d_beat.sop   = x_sop[sel];
      d_beat.eop   = x_eop[sel];
      d_beat.empty = x_empty[sel];
      d_ready      = x_ready[sel];
      mp      = m_valid && src_ready;
      m_pop_v = mp;
      if (mp) m_pop_beat = q[0];
      full = (q.size() == int'(DEPTH));
      nc   = m_cut;
      if (m_sf) begin
         if (!m_cut && full && m_pkt == 0) nc = 1'b1;
         else if (m_cut && mp && q[0].eop) nc = 1'b0;
      end
      nb.data  = snk_data;
      nb.sop   = snk_sop;
      nb.eop   = snk_eop;
      nb.empty = snk_empty;
      if (mp) void'(q.pop_front());
      if (snk_valid) begin
         if (!full || mp) q.push_back(nb);
         else m_ovf = 1'b1;
      end
      if (m_rl > 0) begin
         rh.push_front(m_ready);
         if (rh.size() > m_rl) void'(rh.pop_back());
      end
      m_cut = nc;
      @(posedge clk);
      #1;
      model_eval();
   endtask

   task automatic select(input int s);
      sel  = s;
      m_rl = (s == 1) ? 2 : 0;
      m_sf = (s == 2);
   endtask

   task automatic do_reset();
      snk_valid = 1'b0;
      snk_data  = '0;
      snk_sop   = 1'b0;
      snk_eop   = 1'b0;
      snk_empty = '0;
      src_ready = 1'b0;
      rst       = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      rh.delete();
      m_cut   = 1'b0;
      m_ovf   = 1'b0;
      m_pop_v = 1'b0;
      model_eval();
   endtask

   task automatic test_reset();
      select(0);
      do_reset();
      for (int s = 0; s < 3; s++) begin
         n_total++; if (x_usedw[s] !== '0)   begin n_bad++; $display("FAIL reset_usedw[%0d]: got %0d want 0", s, x_usedw[s]); end
         n_total++; if (x_pkt[s] !== '0)     begin n_bad++; $display("FAIL reset_pkt[%0d]: got %0d want 0", s, x_pkt[s]); end
         n_total++; if (x_ovf[s] !== 1'b0)   begin n_bad++; $display("FAIL reset_ovf[%0d]: got %0b want 0", s, x_ovf[s]); end
         n_total++; if (x_valid[s] !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d]: got %0b want 0", s, x_valid[s]); end
         n_total++; if (x_data[s] !== '0)    begin n_bad++; $display("FAIL reset_data[%0d]: got %0h want 0", s, x_data[s]); end
         n_total++; if (x_ready[s] !== 1'b1) begin n_bad++; $display("FAIL reset_ready[%0d]: got %0b want 1", s, x_ready[s]); end
      end
   endtask

   task automatic test_fill();
      select(0);
      do_reset();
      for (int i = 0; i < 16; i++) begin
         n_total++; if (x_ready[0] !== 1'b1) begin n_bad++; $display("FAIL fill_ready beat %0d: got %0b want 1", i, x_ready[0]); end
         snk_valid = 1'b1;
         snk_data  = $urandom;
         snk_sop   = (i == 0);
         snk_eop   = (i == 15);
         snk_empty = (i == 15) ? EMPTY_W'(2) : '0;
         step();
      end
      snk_valid = 1'b0;
      n_total++; if (x_ready[0] !== 1'b0)   begin n_bad++; $display("FAIL fill_ready_full: got %0b want 0", x_ready[0]); end
      n_total++; if (x_usedw[0] !== UW'(16)) begin n_bad++; $display("FAIL fill_usedw: got %0d want 16", x_usedw[0]); end
      n_total++; if (x_ovf[0] !== 1'b0)     begin n_bad++; $display("FAIL fill_ovf: got %0b want 0", x_ovf[0]); end
      n_total++; if (x_pkt[0] !== UW'(1))    begin n_bad++; $display("FAIL fill_pkt: got %0d want 1", x_pkt[0]); end
      n_total++; if (x_sop[0] !== 1'b1 || x_data[0] !== q[0].data)
         begin n_bad++; $display("FAIL fill_head: got %0h/%0b want %0h/1", x_data[0], x_sop[0], q[0].data); end
   endtask

   task automatic test_rl2();
      bit hist[$];
      select(1);
      do_reset();
      for (int cyc = 0; cyc < 40; cyc++) begin
         snk_valid = (hist.size() >= 2) ? hist[1] : 1'b0;
         snk_data  = $urandom;
         n_total++; if (x_ready[1] !== m_ready) begin n_bad++; $display("FAIL rl2_ready cyc %0d: got %0b want %0b", cyc, x_ready[1], m_ready); end
         step();
         hist.push_front(d_ready);
      end
      snk_valid = 1'b0;
      n_total++; if (x_usedw[1] !== UW'(16)) begin n_bad++; $display("FAIL rl2_usedw: got %0d want 16", x_usedw[1]); end
      n_total++; if (x_ovf[1] !== 1'b0)     begin n_bad++; $display("FAIL rl2_ovf: got %0b want 0", x_ovf[1]); end
      n_total++; if (x_ready[1] !== 1'b0)   begin n_bad++; $display("FAIL rl2_ready_full: got %0b want 0", x_ready[1]); end
   endtask

   task automatic test_back_to_back();
      select(0);
      do_reset();
      for (int i = 0; i < 16; i++) begin
         snk_valid = 1'b1;
         snk_data  = WIDTH'(i);
         snk_sop   = 1'($urandom);
         snk_eop   = 1'($urandom);
         snk_empty = EMPTY_W'($urandom);
         step();
      end
      src_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         snk_data  = WIDTH'(16 + i);
         snk_sop   = 1'($urandom);
         snk_eop   = 1'($urandom);
         snk_empty = EMPTY_W'($urandom);
         step();
         n_total++; if (d_pop !== 1'b1 || d_beat.data !== WIDTH'(i))
            begin n_bad++; $display("FAIL b2b_data %0d: got pop=%0b data=%0h want pop=1 data=%0h", i, d_pop, d_beat.data, i); end
         n_total++; if (d_beat !== m_pop_beat)
            begin n_bad++; $display("FAIL b2b_beat %0d: got %0h want %0h", i, d_beat, m_pop_beat); end
         n_total++; if (x_usedw[0] !== UW'(16))
            begin n_bad++; $display("FAIL b2b_usedw %0d: got %0d want 16", i, x_usedw[0]); end
      end
      snk_valid = 1'b0;
      src_ready = 1'b0;
   endtask

   task automatic test_sf_packet();
      select(2);
      do_reset();
      src_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         snk_valid = 1'b1;
         snk_data  = $urandom;
         snk_sop   = (i == 0);
         snk_eop   = (i == 4);
         snk_empty = (i == 4) ? EMPTY_W'(2) : '0;
         n_total++; if (x_valid[2] !== 1'b0) begin n_bad++; $display("FAIL sf_hold beat %0d: got %0b want 0", i, x_valid[2]); end
         step();
      end
      snk_valid = 1'b0;
      n_total++; if (x_valid[2] !== 1'b1) begin n_bad++; $display("FAIL sf_release: got %0b want 1", x_valid[2]); end
      for (int i = 0; i < 5; i++) begin
         n_total++; if (x_pkt[2] !== UW'(1)) begin n_bad++; $display("FAIL sf_pkt1 %0d: got %0d want 1", i, x_pkt[2]); end
         step();
         n_total++; if (d_pop !== 1'b1 || d_beat !== m_pop_beat)
            begin n_bad++; $display("FAIL sf_beat %0d: got pop=%0b %0h want %0h", i, d_pop, d_beat, m_pop_beat); end
         n_total++; if (d_beat.sop !== (i == 0) || d_beat.eop !== (i == 4) || (i == 4 && d_beat.empty !== EMPTY_W'(2)))
            begin n_bad++; $display("FAIL sf_side %0d: got sop=%0b eop=%0b empty=%0d", i, d_beat.sop, d_beat.eop, d_beat.empty); end
      end
      n_total++; if (x_pkt[2] !== '0)     begin n_bad++; $display("FAIL sf_pkt0: got %0d want 0", x_pkt[2]); end
      n_total++; if (x_valid[2] !== 1'b0) begin n_bad++; $display("FAIL sf_empty_valid: got %0b want 0", x_valid[2]); end
      src_ready = 1'b0;
   endtask

   task automatic test_cut_thru();
      int sent;
      int got;
      select(2);
      do_reset();
      src_ready = 1'b1;
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
         snk_valid = (sent < 20) && x_ready[2];
         snk_data  = WIDTH'(sent);
         snk_sop   = (sent == 0);
         snk_eop   = (sent == 19);
         snk_empty = '0;
         n_total++; if (x_valid[2] !== m_valid) begin n_bad++; $display("FAIL ct_valid cyc %0d: got %0b want %0b", cyc, x_valid[2], m_valid); end
         step();
         if (snk_valid) sent++;
         n_total++; if (d_pop !== m_pop_v) begin n_bad++; $display("FAIL ct_pop cyc %0d: got %0b want %0b", cyc, d_pop, m_pop_v); end
         if (d_pop) begin
            n_total++; if (d_beat.data !== WIDTH'(got) || d_beat !== m_pop_beat)
               begin n_bad++; $display("FAIL ct_data %0d: got %0h want %0h", got, d_beat, m_pop_beat); end
            got++;
         end
      end
      snk_valid = 1'b0;
      n_total++; if (got !== 20)          begin n_bad++; $display("FAIL ct_count: got %0d want 20", got); end
      n_total++; if (x_ovf[2] !== 1'b0)   begin n_bad++; $display("FAIL ct_ovf: got %0b want 0", x_ovf[2]); end
      n_total++; if (x_usedw[2] !== '0)   begin n_bad++; $display("FAIL ct_usedw: got %0d want 0", x_usedw[2]); end
      src_ready = 1'b0;
   endtask

   task automatic test_random(input int s);
      select(s);
      do_reset();
      for (int cyc = 0; cyc < 300; cyc++) begin
         snk_valid = ($urandom_range(0, 99) < 60);
         snk_data  = $urandom;
         snk_sop   = 1'($urandom);
         snk_eop   = ($urandom_range(0, 7) == 0);
         snk_empty = EMPTY_W'($urandom);
         src_ready = ($urandom_range(0, 99) < 50);
         n_total++; if (x_usedw[s] !== UW'(m_usedw)) begin n_bad++; $display("FAIL rnd%0d_usedw cyc %0d: got %0d want %0d", s, cyc, x_usedw[s], m_usedw); end
         n_total++; if (x_valid[s] !== m_valid)      begin n_bad++; $display("FAIL rnd%0d_valid cyc %0d: got %0b want %0b", s, cyc, x_valid[s], m_valid); end
         n_total++; if (x_ready[s] !== m_ready)      begin n_bad++; $display("FAIL rnd%0d_ready cyc %0d: got %0b want %0b", s, cyc, x_ready[s], m_ready); end
         step();
         n_total++; if (d_pop !== m_pop_v) begin n_bad++; $display("FAIL rnd%0d_pop cyc %0d: got %0b want %0b", s, cyc, d_pop, m_pop_v); end
         if (m_pop_v) begin
            n_total++; if (d_beat !== m_pop_beat) begin n_bad++; $display("FAIL rnd%0d_beat cyc %0d: got %0h want %0h", s, cyc, d_beat, m_pop_beat); end
         end
      end
      snk_valid = 1'b0;
      src_ready = 1'b0;
      n_total++; if (x_ovf[s] !== m_ovf)       begin n_bad++; $display("FAIL rnd%0d_ovf: got %0b want %0b", s, x_ovf[s], m_ovf); end
      n_total++; if (x_pkt[s] !== UW'(m_pkt))  begin n_bad++; $display("FAIL rnd%0d_pkt: got %0d want %0d", s, x_pkt[s], m_pkt); end
   endtask

   task automatic test_ovf_reset();
      select(0);
      do_reset();
      for (int i = 0; i < 17; i++) begin
         snk_valid = 1'b1;
         snk_data  = $urandom;
         step();
      end
      snk_valid = 1'b0;
      n_total++; if (x_ovf[0] !== 1'b1)      begin n_bad++; $display("FAIL ovf_set: got %0b want 1", x_ovf[0]); end
      n_total++; if (x_usedw[0] !== UW'(16)) begin n_bad++; $display("FAIL ovf_usedw: got %0d want 16", x_usedw[0]); end
      n_total++; if (x_data[0] !== q[0].data) begin n_bad++; $display("FAIL ovf_head: got %0h want %0h", x_data[0], q[0].data); end
      step();
      n_total++; if (x_ovf[0] !== 1'b1)      begin n_bad++; $display("FAIL ovf_sticky: got %0b want 1", x_ovf[0]); end
      // Reset lands mid-cycle while a beat is being offered.
      snk_valid = 1'b1;
      src_ready = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      n_total++; if (x_usedw[0] !== '0)   begin n_bad++; $display("FAIL rst_usedw: got %0d want 0", x_usedw[0]); end
      n_total++; if (x_valid[0] !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b want 0", x_valid[0]); end
      n_total++; if (x_ovf[0] !== 1'b0)   begin n_bad++; $display("FAIL rst_ovf: got %0b want 0", x_ovf[0]); end
      n_total++; if (x_pkt[0] !== '0)     begin n_bad++; $display("FAIL rst_pkt: got %0d want 0", x_pkt[0]); end
      n_total++; if (x_ready[0] !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b want 1", x_ready[0]); end
      do_reset();
   endtask

   initial begin
      rst       = 1'b1;
      snk_valid = 1'b0;
      snk_data  = '0;
      snk_sop   = 1'b0;
      snk_eop   = 1'b0;
      snk_empty = '0;
      src_ready = 1'b0;
      sel       = 0;
      test_reset();
      test_fill();
      test_rl2();
      test_back_to_back();
      test_sf_packet();
      test_cut_thru();
      test_random(0);
      test_random(2);
      test_ovf_reset();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
